// File: rtl/inverter_loop_tester.sv
// Purpose: drives a toggling pattern into the analog double-inverter macro, checks each edge returns, and records latency and errors.
// Latency: each ideal step takes 4 cycles (toggle + 3 wait); last_lat includes the SYNC_STAGES-cycle synchronizer delay.
// Backpressure: none; start is sampled only in IDLE/DONE and ignored while busy, and mode is read only on the start edge.
module inverter_loop_tester #(
    parameter int TIMEOUT     = 15,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       resp_in,
    output logic       stim_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_cnt,
    output logic [3:0] last_lat,
    output logic [3:0] max_lat
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_TOGGLE,
        S_WAIT,
        S_DONE
    } state_t;

    // Last wait_cnt value before an edge is declared failed, and the latency reported for a failure.
    localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
    localparam logic [3:0] TO_FAIL = 4'(TIMEOUT);

    state_t                 state_q, state_d;
    logic                   stim_q, stim_d;
    logic [3:0]             wait_q, wait_d;
    logic [8:0]             step_q, step_d;
    logic [8:0]             steps_q, steps_d;
    logic [7:0]             err_q, err_d;
    logic [3:0]             last_q, last_d;
    logic [3:0]             max_q, max_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   resp_s;
    logic [3:0]             lat;
    logic                   edge_end;

    function automatic logic [8:0] steps_for(input logic [1:0] m);
        case (m)
            2'd0:    return 9'd2;
            2'd1:    return 9'd16;
            2'd2:    return 9'd64;
            default: return 9'd256;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    assign resp_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous macro output into the clock domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], resp_in};
        end
    end

    // State and measurement registers; reset overrides every other event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            stim_q  <= 1'b0;
            wait_q  <= '0;
            step_q  <= '0;
            steps_q <= '0;
            err_q   <= '0;
            last_q  <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            stim_q  <= stim_d;
            wait_q  <= wait_d;
            step_q  <= step_d;
            steps_q <= steps_d;
            err_q   <= err_d;
            last_q  <= last_d;
            max_q   <= max_d;
        end
    end

    // Sequencer: settle check, then toggle/wait per step, then hold results in DONE.
    always_comb begin
        state_d  = state_q;
        stim_d   = stim_q;
        wait_d   = wait_q;
        step_d   = step_q;
        steps_d  = steps_q;
        err_d    = err_q;
        last_d   = last_q;
        max_d    = max_q;
        lat      = '0;
        edge_end = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (state_q == S_IDLE) begin
                    stim_d = 1'b0;
                end
                if (start) begin
                    // A restart from DONE also returns the macro input low before settling.
                    state_d = S_SETTLE;
                    stim_d  = 1'b0;
                    steps_d = steps_for(mode);
                    err_d   = '0;
                    last_d  = '0;
                    max_d   = '0;
                    wait_d  = '0;
                    step_d  = '0;
                end
            end
            S_SETTLE: begin
                if (!resp_s) begin
                    state_d = S_TOGGLE;
                end else if (wait_q == TO_LAST) begin
                    err_d   = sat_inc(err_q);
                    state_d = S_TOGGLE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_TOGGLE: begin
                stim_d  = ~stim_q;
                wait_d  = '0;
                step_d  = step_q + 9'd1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A match on the final wait cycle still counts as a match.
                if (resp_s == stim_q) begin
                    lat      = wait_q;
                    edge_end = 1'b1;
                end else if (wait_q == TO_LAST) begin
                    lat      = TO_FAIL;
                    edge_end = 1'b1;
                    err_d    = sat_inc(err_q);
                end else begin
                    wait_d = wait_q + 4'd1;
                end
                if (edge_end) begin
                    last_d = lat;
                    if (lat > max_q) begin
                        max_d = lat;
                    end
                    state_d = (step_q == steps_q) ? S_DONE : S_TOGGLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign stim_out = stim_q;
    assign busy     = (state_q == S_SETTLE) || (state_q == S_TOGGLE) || (state_q == S_WAIT);
    assign done     = (state_q == S_DONE);
    assign pass     = done && (err_q == 8'd0);
    assign err_cnt  = err_q;
    assign last_lat = last_q;
    assign max_lat  = max_q;

endmodule

// File: tb/tb_inverter_loop_tester.sv
// Bench for inverter_loop_tester: a loop responder emulates the macro, and every run is
// checked against a cycle walk over the recorded resp_in history using the sequencing rules.
// Directed runs cover the documented scenarios; randomized runs vary loop type, delay and mode.
module tb_inverter_loop_tester;
    localparam int TO = 15;
    localparam int SS = 2;
    localparam int HIST = 32768;

    logic       clk;
    logic       rst;
    logic       start;
    logic [1:0] mode;
    logic       resp_in;
    logic       stim_out;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [3:0] last_lat;
    logic [3:0] max_lat;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int loop_kind = 1;
    int loop_dly  = 0;
    int s_run = 32'h7fff_ffff;
    int run_d = 0;
    bit r_hist [HIST];
    bit s_hist [HIST];

    inverter_loop_tester dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .resp_in  (resp_in),
        .stim_out (stim_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .last_lat (last_lat),
        .max_lat  (max_lat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Record the resp_in value sampled at each edge, indexed by edge number.
    always @(posedge clk) begin
        if (cyc < HIST) r_hist[cyc] <= resp_in;
        cyc <= cyc + 1;
    end

    // Macro emulation; drives resp_in 1 time unit after each edge.
    // Kinds: 0 loop delayed by loop_dly cycles, 1 stuck 0, 2 stuck 1, 3 inverted, 4 noise,
    // 5 inverted with the synchronizer lag pre-compensated, so the sampled response is
    // always the inverse of the current stimulus assuming every step times out.
    initial begin
        resp_in = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (cyc - 1 < HIST) s_hist[cyc-1] = stim_out;
            case (loop_kind)
                0: resp_in = (cyc - 1 >= loop_dly) ? s_hist[cyc-1-loop_dly] : 1'b0;
                1: resp_in = 1'b0;
                2: resp_in = 1'b1;
                3: resp_in = ~stim_out;
                4: resp_in = 1'($urandom);
                default: resp_in = (cyc < s_run) ? 1'b1 : ((((cyc + 1 - s_run) / 16) % 2) == 0);
            endcase
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int steps_of(input int m);
        return (m == 0) ? 2 : (m == 1) ? 16 : (m == 2) ? 64 : 256;
    endfunction

    // Walk the rules over the recorded response: resp_s at edge t is resp_in sampled at edge t-SS.
    function automatic void model_run(input int s, input int steps,
                                      output int e_err, output int e_last,
                                      output int e_max, output int e_end);
        int t;
        int w;
        bit st;
        e_err = 0; e_last = 0; e_max = 0; st = 1'b0; t = s + 1; w = 0;
        while (1) begin
            if (r_hist[t-SS] == 1'b0) begin t++; break; end
            if (w == TO - 1) begin e_err++; t++; break; end
            w++; t++;
        end
        for (int n = 0; n < steps; n++) begin
            st = ~st; t++; w = 0;
            while (1) begin
                if (r_hist[t-SS] == st) begin e_last = w; t++; break; end
                if (w == TO - 1) begin
                    e_last = TO;
                    if (e_err < 255) e_err++;
                    t++;
                    break;
                end
                w++; t++;
            end
            if (e_last > e_max) e_max = e_last;
        end
        e_end = t - 1;
    endfunction

    task automatic run(input int kind, input int m, input int dly, input bit poke);
        int ee, el, em, eend;
        bit got;
        loop_kind = kind;
        loop_dly  = dly;
        s_run     = 32'h7fff_ffff;
        repeat (3) begin @(posedge clk); #1; end
        start = 1'b1;
        mode  = 2'(m);
        s_run = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = 2'($urandom);
        chk("start_busy", int'(busy), 1);
        chk("start_err_clr", int'(err_cnt), 0);
        chk("start_max_clr", int'(max_lat), 0);
        chk("start_last_clr", int'(last_lat), 0);
        chk("start_stim_low", int'(stim_out), 0);
        got = 1'b0;
        run_d = 0;
        for (int i = 0; i < 6000 && !got; i++) begin
            if (poke) begin
                start = (i >= 20 && i < 24);
                mode  = 2'($urandom);
            end
            @(posedge clk); #1;
            if (done) begin got = 1'b1; run_d = cyc - 1; end
        end
        start = 1'b0;
        chk("done_reached", int'(got), 1);
        model_run(s_run, steps_of(m), ee, el, em, eend);
        chk("done_edge", run_d, eend);
        chk("err_cnt", int'(err_cnt), ee);
        chk("last_lat", int'(last_lat), el);
        chk("max_lat", int'(max_lat), em);
        chk("pass", int'(pass), (ee == 0) ? 1 : 0);
        chk("end_stim", int'(stim_out), 0);
        chk("end_busy", int'(busy), 0);
        repeat (3) begin @(posedge clk); #1; end
        chk("done_hold", int'(done), 1);
        chk("err_hold", int'(err_cnt), ee);
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'd0;
        repeat (3) begin @(posedge clk); #1; end
        chk("rst_stim", int'(stim_out), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_last", int'(last_lat), 0);
        chk("rst_max", int'(max_lat), 0);
        rst = 1'b0;

        // Ideal loop, 2 steps.
        run(0, 0, 0, 1'b0);
        chk("ideal_done_at_s9", run_d, s_run + 9);
        chk("ideal_lat2", int'(last_lat), 2);
        chk("ideal_max2", int'(max_lat), 2);
        chk("ideal_pass", int'(pass), 1);

        // Loop delayed by 5 cycles, 16 steps.
        run(0, 1, 5, 1'b0);
        chk("dly5_lat7", int'(last_lat), 7);
        chk("dly5_max7", int'(max_lat), 7);
        chk("dly5_err0", int'(err_cnt), 0);

        // Response stuck at 0: first edge times out, second matches at once.
        run(1, 0, 0, 1'b0);
        chk("stuck0_err1", int'(err_cnt), 1);
        chk("stuck0_max15", int'(max_lat), 15);
        chk("stuck0_last0", int'(last_lat), 0);
        chk("stuck0_pass0", int'(pass), 0);

        // Restart from DONE after the failing run, ideal loop.
        run(0, 0, 0, 1'b0);
        chk("restart_pass", int'(pass), 1);

        // Every edge fails: settle + 16 steps, then settle + 256 steps saturating.
        run(5, 1, 0, 1'b0);
        chk("inv16_err17", int'(err_cnt), 17);
        run(5, 3, 0, 1'b0);
        chk("inv256_sat", int'(err_cnt), 255);

        // start/mode activity while busy must not disturb a 64-step run.
        run(0, 2, 0, 1'b1);
        chk("busy_start_ignored", run_d, s_run + 1 + 4 * 64);

        // Reset pulsed mid-WAIT.
        loop_kind = 1;
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1;
        mode  = 2'd2;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("midrst_busy_before", int'(busy), 1);
        chk("midrst_err_before", int'(err_cnt != 8'd0), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_stim", int'(stim_out), 0);
        chk("midrst_err", int'(err_cnt), 0);
        chk("midrst_last", int'(last_lat), 0);
        chk("midrst_max", int'(max_lat), 0);
        @(posedge clk); #1;
        chk("midrst_idle_stays", int'(busy), 0);

        // Randomized runs against the rule walk.
        for (int i = 0; i < 8; i++) begin
            run($urandom_range(0, 4), $urandom_range(0, 2), $urandom_range(0, 14), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
